// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode field layout, the NOP/HALT opcodes used by
// both the fetch front end and the decoder, and the fetch FSM states.
package cpu_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;

  localparam logic [4:0]  OPC_NOP   = 5'b00000;
  localparam logic [4:0]  OPC_HALT  = 5'b11111;
  localparam logic [15:0] INSTR_NOP = 16'h0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  // Extract the opcode field from a 16-bit instruction word.
  function automatic logic [4:0] get_opcode(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch front end: owns the PC, drives the 1-cycle-latency
// instruction memory, squashes the wrong-path word on a taken branch,
// honours downstream stalls and stops fetching on a HALT opcode.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int                    PROG_CTR_WID = 10,
  parameter logic [PROG_CTR_WID-1:0] RESET_VECTOR = '0,
  parameter logic [4:0]            HALT_OPCODE  = OPC_HALT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    branch_taken_EX,
  input  logic [PROG_CTR_WID-1:0] branch_target_EX,
  output logic [PROG_CTR_WID-1:0] instr_mem_addr,
  output logic                    instr_mem_rd_en,
  input  logic [15:0]             instr_mem_dout,
  output logic [15:0]             instr_out,
  output logic                    instr_valid,
  output logic [PROG_CTR_WID-1:0] instr_pc,
  output logic                    halted
);

  localparam logic [PROG_CTR_WID-1:0] PC_ONE = PROG_CTR_WID'(1);

  fetch_state_e              state_q, state_d;
  logic [PROG_CTR_WID-1:0]   pc_q, pc_d;
  logic [PROG_CTR_WID-1:0]   fetch_pc_q, fetch_pc_d;
  logic                      valid_q, valid_d;

  assign instr_pc = fetch_pc_q;
  assign halted   = (state_q == S_HALT);

  // Fetch state, PC and in-flight word tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      fetch_pc_q <= RESET_VECTOR;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state, memory request and IF/ID output selection.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    fetch_pc_d      = fetch_pc_q;
    valid_d         = valid_q;
    instr_mem_addr  = pc_q;
    instr_mem_rd_en = 1'b0;
    instr_valid     = valid_q;
    instr_out       = valid_q ? instr_mem_dout : INSTR_NOP;

    if (branch_taken_EX) begin
      // Redirect bypasses the PC register so the target is read this cycle;
      // whatever is on instr_out now came from the wrong path.
      instr_mem_addr  = branch_target_EX;
      instr_mem_rd_en = 1'b1;
      pc_d            = branch_target_EX + PC_ONE;
      fetch_pc_d      = branch_target_EX;
      valid_d         = 1'b1;
      state_d         = S_RUN;
      instr_valid     = 1'b0;
      instr_out       = INSTR_NOP;
    end else begin
      unique case (state_q)
        S_BOOT: begin
          instr_mem_rd_en = 1'b1;
          pc_d            = pc_q + PC_ONE;
          fetch_pc_d      = pc_q;
          valid_d         = 1'b1;
          state_d         = S_RUN;
        end
        S_RUN: begin
          if (!stall) begin
            if (valid_q && (get_opcode(instr_mem_dout) == HALT_OPCODE)) begin
              // HALT goes out once as a valid word; pc_q already points past it.
              valid_d = 1'b0;
              state_d = S_HALT;
            end else begin
              instr_mem_rd_en = 1'b1;
              pc_d            = pc_q + PC_ONE;
              fetch_pc_d      = pc_q;
              valid_d         = 1'b1;
            end
          end
        end
        S_HALT: begin
          valid_d = 1'b0;
        end
        default: begin
          state_d = S_BOOT;
        end
      endcase
    end

    // No memory traffic while reset is held.
    if (rst) begin
      instr_mem_rd_en = 1'b0;
    end
  end

endmodule
